// File: rtl/inst_loader_if.sv
// Host-side bundle of the instruction loader: symbolic instruction handshake,
// session control, instruction-memory write port and session status.
interface inst_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;

  // Host / boot controller side
  modport master (
    output start, finish, in_valid, op, rd, rs1, rs2, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, done, err
  );

  // Loader side
  modport slave (
    input  start, finish, in_valid, op, rd, rs1, rs2, imm,
    output in_ready, imem_we, imem_addr, imem_wdata, count, done, err
  );
endinterface

// File: rtl/inst_loader.sv
// Sequential RV32I encoder and program loader. Accepts symbolic instructions,
// encodes them into RV32I words and writes them to consecutive word addresses
// of instruction memory, one registered write strobe per accepted word.
module inst_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input logic         clk,
  input logic         rst,
  inst_loader_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_OPIM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STOR = 7'b0100011;
  localparam logic [6:0] OPC_BRCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] imm;
  logic [31:0] enc;
  logic        legal;
  logic        i_ok, b_ok, j_ok;
  logic        ready;
  logic        accept;
  logic        wr;

  assign imm = bus.imm;

  // Signed immediate range checks; branch and jump offsets must also be even
  assign i_ok = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
  assign b_ok = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
  assign j_ok = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];

  assign ready  = (state_q == S_LOAD) && (count_q < DEPTH_C) && !bus.finish;
  assign accept = bus.in_valid && ready;
  assign wr     = accept && legal;

  // Encode the symbolic instruction and flag illegal ops or out-of-range immediates
  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (bus.op)
      4'd0: begin enc = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, OPC_R}; legal = 1'b1; end
      4'd1: begin enc = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, OPC_R}; legal = 1'b1; end
      4'd2: begin enc = {7'b0000000, bus.rs2, bus.rs1, 3'b100, bus.rd, OPC_R}; legal = 1'b1; end
      4'd3: begin enc = {7'b0000000, bus.rs2, bus.rs1, 3'b101, bus.rd, OPC_R}; legal = 1'b1; end
      4'd4: begin enc = {7'b0000000, bus.rs2, bus.rs1, 3'b110, bus.rd, OPC_R}; legal = 1'b1; end
      4'd5: begin enc = {7'b0000000, bus.rs2, bus.rs1, 3'b111, bus.rd, OPC_R}; legal = 1'b1; end
      4'd6: begin enc = {imm[11:0], bus.rs1, 3'b000, bus.rd, OPC_OPIM}; legal = i_ok; end
      4'd7: begin enc = {imm[11:0], bus.rs1, 3'b010, bus.rd, OPC_LOAD}; legal = i_ok; end
      4'd8: begin enc = {imm[11:5], bus.rs2, bus.rs1, 3'b010, imm[4:0], OPC_STOR}; legal = i_ok; end
      4'd9: begin
        enc   = {imm[12], imm[10:5], bus.rs2, bus.rs1, 3'b000, imm[4:1], imm[11], OPC_BRCH};
        legal = b_ok;
      end
      4'd10: begin
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, OPC_JAL};
        legal = j_ok;
      end
      4'd11: begin enc = {imm[11:0], bus.rs1, 3'b000, bus.rd, OPC_JALR}; legal = i_ok; end
      default: begin enc = '0; legal = 1'b0; end
    endcase
  end

  // Session FSM: start opens a session from address 0, finish or a full memory closes it
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.finish) begin
          state_d = S_DONE;
        end else if (accept) begin
          if (legal) begin
            count_d = count_q + 1'b1;
            if (count_q == DEPTH_C - 1'b1) state_d = S_DONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers and the registered write port; reset also suppresses a same-edge write
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= wr;
      if (wr) begin
        addr_q  <= count_q[ADDR_W-1:0];
        wdata_q <= enc;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.count      = count_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed scenarios plus randomized instruction
// streams checked against a field-arithmetic RV32I encoder and a queue model.
module tb_inst_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_loader_if #(.ADDR_W(10)) b ();
  inst_loader_if #(.ADDR_W(2))  f ();

  inst_loader #(.ADDR_W(10), .DEPTH(1024)) dut      (.clk(clk), .rst(rst), .bus(b));
  inst_loader #(.ADDR_W(2),  .DEPTH(4))    dut_full (.clk(clk), .rst(rst), .bus(f));

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  localparam int DEPTH_B = 1024;

  wr_t obs[$], exp_q[$], obsf[$];
  wr_t mon_e, monf_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;

  // reference model of the session
  bit m_load, m_done, m_err;
  int m_count;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b.imem_we === 1'b1) begin
      mon_e.addr = int'(b.imem_addr); mon_e.data = b.imem_wdata; mon_e.cyc = cyc;
      obs.push_back(mon_e);
    end
    if (f.imem_we === 1'b1) begin
      monf_e.addr = int'(f.imem_addr); monf_e.data = f.imem_wdata; monf_e.cyc = cyc;
      obsf.push_back(monf_e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                          input int rs2, input int imm, output bit legal);
    int w, f3, opc;
    w = 0; legal = 1'b1; f3 = 0; opc = 0;
    case (op)
      0, 1, 2, 3, 4, 5: begin
        f3 = (op < 2) ? 0 : op + 2;
        w  = (((op == 1) ? 32 : 0) << 25) | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 'h33;
      end
      6, 7, 11: begin
        legal = imm >= -2048 && imm <= 2047;
        f3  = (op == 7) ? 2 : 0;
        opc = (op == 6) ? 'h13 : (op == 7) ? 'h03 : 'h67;
        w   = ((imm & 'hfff) << 20) | rs1 << 15 | f3 << 12 | rd << 7 | opc;
      end
      8: begin
        legal = imm >= -2048 && imm <= 2047;
        w = (((imm >> 5) & 'h7f) << 25) | rs2 << 20 | rs1 << 15 | 2 << 12 | ((imm & 'h1f) << 7) | 'h23;
      end
      9: begin
        legal = imm >= -4096 && imm <= 4094 && ((imm & 1) == 0);
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25) | rs2 << 20 | rs1 << 15 |
            (((imm >> 1) & 'hf) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
      end
      10: begin
        legal = imm >= -1048576 && imm <= 1048574 && ((imm & 1) == 0);
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21) | (((imm >> 11) & 1) << 20) |
            (((imm >> 12) & 'hff) << 12) | rd << 7 | 'h6f;
      end
      default: legal = 1'b0;
    endcase
    return 32'(w);
  endfunction

  task automatic model_reset();
    m_load = 0; m_done = 0; m_err = 0; m_count = 0;
  endtask

  task automatic do_start();
    b.in_valid = 1'b0;
    b.start = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    if (!m_load) begin m_load = 1; m_done = 0; m_count = 0; m_err = 0; end
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
    bit exp_ready, legal;
    wr_t e;
    b.op = 4'(op); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2); b.imm = imm;
    b.in_valid = 1'b1;
    @(negedge clk);
    exp_ready = m_load && (m_count < DEPTH_B);
    checks++;
    if (b.in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready op=%0d imm=%0d count=%0d: got %b want %b", op, imm, m_count, b.in_ready, exp_ready);
    end
    @(posedge clk); #1;
    if (exp_ready) begin
      e.data = ref_enc(op, rd, rs1, rs2, imm, legal);
      if (legal) begin
        e.addr = m_count; e.cyc = cyc;
        exp_q.push_back(e);
        m_count++;
        if (m_count == DEPTH_B) begin m_load = 0; m_done = 1; end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic do_finish();
    b.finish = 1'b1;
    @(negedge clk);
    checks++;
    if (b.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_with_finish: got %b want 0", b.in_ready);
    end
    @(posedge clk); #1;
    b.finish = 1'b0;
    b.in_valid = 1'b0;
    if (m_load) begin m_load = 0; m_done = 1; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b.in_ready, b.imem_we, b.imem_addr, b.imem_wdata, b.count, b.done, b.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b a=%0d d=%h cnt=%0d done=%b err=%b want all 0",
               b.in_ready, b.imem_we, b.imem_addr, b.imem_wdata, b.count, b.done, b.err);
    end
    checks++;
    if ({f.in_ready, f.imem_we, f.imem_addr, f.imem_wdata, f.count, f.done, f.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_full: cnt=%0d done=%b we=%b want all 0", f.count, f.done, f.imem_we);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [31:0] kw [5];
    kw = '{32'h00500093, 32'h002081B3, 32'h402081B3, 32'h0020A423, 32'hFFC0A283};
    do_start();
    send(6, 1, 0, 0, 5);
    send(0, 3, 1, 2, 0);
    send(1, 3, 1, 2, 0);
    send(8, 0, 1, 2, 8);
    send(7, 5, 1, 0, -4);
    do_finish();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i < obs.size()) begin
        checks++;
        if (obs[i].data !== kw[i] || obs[i].addr != i) begin
          errors++;
          $display("FAIL basic_known[%0d]: got a=%0d d=%h want a=%0d d=%h", i, obs[i].addr, obs[i].data, i, kw[i]);
        end
      end
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_nwrites: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL basic_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                 obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++;
    if (b.count !== 11'd5 || b.done !== 1'b1 || b.err !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: got cnt=%0d done=%b err=%b want cnt=5 done=1 err=0", b.count, b.done, b.err);
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_branch();
    logic [31:0] kw [3];
    kw = '{32'hFE208CE3, 32'h010000EF, 32'h00008067};
    do_start();
    send(9, 0, 1, 2, -8);
    send(10, 1, 0, 0, 16);
    send(11, 0, 1, 0, 0);
    do_finish();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i < obs.size()) begin
        checks++;
        if (obs[i].data !== kw[i]) begin
          errors++;
          $display("FAIL branch_known[%0d]: got %h want %h", i, obs[i].data, kw[i]);
        end
      end
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL branch_nwrites: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL branch_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                 obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reject();
    do_start();
    send(9, 0, 1, 2, 3);
    send(6, 1, 0, 0, 4096);
    send(13, 1, 2, 3, 0);
    send(6, 1, 0, 0, 1);
    do_finish();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs.size() != 1 || obs[0].addr != 0 || obs[0].data !== 32'h00100093) begin
      errors++;
      $display("FAIL reject_writes: got n=%0d first=%h want n=1 first=00100093 at 0",
               obs.size(), (obs.size() > 0) ? obs[0].data : 32'h0);
    end
    checks++;
    if (b.err !== m_err || b.count !== 11'(m_count) || b.err !== 1'b1 || b.count !== 11'd1) begin
      errors++;
      $display("FAIL reject_status: got err=%b cnt=%0d want err=1 cnt=1", b.err, b.count);
    end
    obs.delete(); exp_q.delete();
    do_start();
    @(negedge clk);
    checks++;
    if (b.err !== 1'b0 || b.count !== 11'd0 || b.done !== 1'b0) begin
      errors++;
      $display("FAIL restart_clears: got err=%b cnt=%0d done=%b want 0 0 0", b.err, b.count, b.done);
    end
    do_finish();
  endtask

  task automatic test_full();
    bit  rdy [6];
    bit  lg;
    wr_t e;
    wr_t expf[$];
    f.start = 1'b1;
    @(posedge clk); #1;
    f.start = 1'b0;
    f.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f.op = 4'd6; f.rd = 5'(i + 1); f.rs1 = 5'd0; f.rs2 = 5'd0; f.imm = i;
      @(negedge clk);
      rdy[i] = f.in_ready;
      @(posedge clk); #1;
      if (i < 4) begin
        e.addr = i; e.data = ref_enc(6, i + 1, 0, 0, i, lg); e.cyc = cyc;
        expf.push_back(e);
      end
    end
    f.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rdy[i] != (i < 4)) begin
        errors++;
        $display("FAIL full_ready[%0d]: got %b want %b", i, rdy[i], (i < 4));
      end
    end
    checks++;
    if (obsf.size() != 4) begin
      errors++;
      $display("FAIL full_nwrites: got %0d want 4", obsf.size());
    end
    for (int i = 0; i < obsf.size() && i < 4; i++) begin
      checks++;
      if (obsf[i].addr != expf[i].addr || obsf[i].data !== expf[i].data || obsf[i].cyc != expf[i].cyc) begin
        errors++;
        $display("FAIL full_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                 obsf[i].addr, obsf[i].data, obsf[i].cyc, expf[i].addr, expf[i].data, expf[i].cyc);
      end
    end
    checks++;
    if (f.done !== 1'b1 || f.count !== 3'd4 || f.err !== 1'b0) begin
      errors++;
      $display("FAIL full_status: got done=%b cnt=%0d err=%b want done=1 cnt=4 err=0", f.done, f.count, f.err);
    end
    obsf.delete();
  endtask

  task automatic test_controls();
    do_start();
    send(6, 1, 0, 0, 10);
    send(6, 2, 0, 0, 20);
    do_start();
    @(negedge clk);
    checks++;
    if (b.count !== 11'd2 || b.done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_load: got cnt=%0d done=%b want cnt=2 done=0", b.count, b.done);
    end
    b.op = 4'd6; b.rd = 5'd3; b.rs1 = 5'd0; b.rs2 = 5'd0; b.imm = 30;
    b.in_valid = 1'b1;
    do_finish();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs.size() != exp_q.size() || obs.size() != 2) begin
      errors++;
      $display("FAIL finish_drop_nwrites: got %0d want 2", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL controls_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                 obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++;
    if (b.count !== 11'd2 || b.done !== 1'b1) begin
      errors++;
      $display("FAIL controls_status: got cnt=%0d done=%b want cnt=2 done=1", b.count, b.done);
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    do_start();
    send(6, 1, 0, 0, 1);
    send(6, 2, 0, 0, 2);
    b.op = 4'd6; b.rd = 5'd3; b.rs1 = 5'd0; b.imm = 3;
    b.in_valid = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({b.in_ready, b.imem_we, b.imem_addr, b.imem_wdata, b.count, b.done, b.err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b we=%b a=%0d d=%h cnt=%0d done=%b err=%b want all 0",
               b.in_ready, b.imem_we, b.imem_addr, b.imem_wdata, b.count, b.done, b.err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    b.in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (b.done !== 1'b0 || b.in_ready !== 1'b0 || b.count !== 11'd0) begin
      errors++;
      $display("FAIL midreset_idle: got done=%b rdy=%b cnt=%0d want 0 0 0", b.done, b.in_ready, b.count);
    end
    do_start();
    send(6, 4, 0, 0, 7);
    do_finish();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs.size() != exp_q.size() || obs.size() != 3) begin
      errors++;
      $display("FAIL midreset_nwrites: got %0d want 3", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL midreset_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                 obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int bop  [14];
    int bimm [14];
    int op, imm;
    bop  = '{6, 6, 6, 6, 8, 7, 9, 9, 9, 9, 10, 10, 10, 10};
    bimm = '{2047, -2048, 2048, -2049, -2049, 2047, 4094, -4096, 4096, 5,
             1048574, -1048576, 1048576, 1048575};
    do_start();
    for (int i = 0; i < 14; i++)
      send(bop[i], int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), bimm[i]);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b.in_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        op = int'($urandom_range(0, 15));
        case ($urandom_range(0, 2))
          0:       imm = int'($urandom_range(0, 8191)) - 4096;
          1:       imm = int'($urandom_range(0, 4194303)) - 2097152;
          default: imm = int'($urandom_range(0, 31)) - 16;
        endcase
        send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
      end
    end
    do_finish();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_nwrites: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL random_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                 obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++;
    if (b.count !== 11'(m_count) || b.done !== m_done || b.err !== m_err) begin
      errors++;
      $display("FAIL random_status: got cnt=%0d done=%b err=%b want cnt=%0d done=%b err=%b",
               b.count, b.done, b.err, m_count, m_done, m_err);
    end
    obs.delete(); exp_q.delete();
  endtask

  initial begin
    b.start = 1'b0; b.finish = 1'b0; b.in_valid = 1'b0;
    b.op = '0; b.rd = '0; b.rs1 = '0; b.rs2 = '0; b.imm = '0;
    f.start = 1'b0; f.finish = 1'b0; f.in_valid = 1'b0;
    f.op = '0; f.rd = '0; f.rs1 = '0; f.rs2 = '0; f.imm = '0;
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_branch();
    test_reject();
    test_full();
    test_controls();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
